// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target exposing NREGS 8-bit registers, also reachable over a Wishbone classic port.
// The I2C write wins when both ports write the same register in the same clk.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int         NREGS    = 16,
  localparam int        AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_oe,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  output logic          wb_ack_o,
  output logic          o_int
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_e;

  state_e state_q, state_d;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          wrote_q, wrote_d;
  logic          int_q, int_d;
  logic [7:0]    regs_q [NREGS];

  logic          wb_ack_q, wb_ack_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic          wb_hit;

  logic          i2c_we;
  logic [7:0]    byte_in;
  logic          scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic          unused_wb_hi;

  assign unused_wb_hi = ^wb_dat_i[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise   = scl_sync_q & ~scl_prev_q;
  assign scl_fall   = ~scl_sync_q & scl_prev_q;
  assign start_det  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign byte_in    = {shift_q[6:0], sda_sync_q};
  assign addr_match = (shift_q[7:1] == I2C_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:      if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall) state_d = shift_q[0] ? RDATA : PTR;
        PTR:       if (scl_fall && bit_cnt_q == 4'd8) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall) state_d = WDATA;
        WDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_sync_q)                  state_d = IDLE;
          else if (scl_fall && bit_cnt_q == 4'd9)      state_d = RDATA;
        end
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wrote_d   = wrote_q;
    int_d     = 1'b0;
    i2c_we    = 1'b0;
    case (state_q)
      ADDR, PTR, WDATA: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7 && state_q == PTR) ptr_d = byte_in[AW-1:0];
          if (bit_cnt_q == 4'd7 && state_q == WDATA) begin
            i2c_we  = 1'b1;
            ptr_d   = ptr_q + AW'(1);
            wrote_d = 1'b1;
          end
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d = (state_q != ADDR) || addr_match;
        end
      end
      ADDR_ACK, PTR_ACK, WDATA_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
          if (state_q == ADDR_ACK && shift_q[0]) begin
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
          end
        end
      end
      RDATA: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + AW'(1);
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      RDATA_ACK: begin
        // bit_cnt=9 marks a sampled ACK; the next byte is loaded on the following fall
        if (scl_rise && !sda_sync_q) begin
          bit_cnt_d = 4'd9;
        end else if (scl_fall && bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          shift_d   = regs_q[ptr_q];
          sda_oe_d  = ~regs_q[ptr_q][7];
        end
      end
      default: ;
    endcase
    if (stop_det) begin
      sda_oe_d = 1'b0;
      int_d    = wrote_q;
      wrote_d  = 1'b0;
    end else if (start_det) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      wrote_d   = 1'b0;
    end
  end

  assign wb_hit   = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign wb_ack_d = wb_hit;
  assign wb_dat_d = (wb_hit && !wb_we_i) ? {24'b0, regs_q[wb_adr_i]} : wb_dat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wrote_q   <= 1'b0;
      int_q     <= 1'b0;
      wb_ack_q  <= 1'b0;
      wb_dat_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wrote_q   <= wrote_d;
      int_q     <= int_d;
      wb_ack_q  <= wb_ack_d;
      wb_dat_q  <= wb_dat_d;
      if (wb_hit && wb_we_i) regs_q[wb_adr_i] <= wb_dat_i[7:0];
      if (i2c_we)            regs_q[ptr_q]    <= byte_in;
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oe   = sda_oe_q;
  assign o_int    = int_q;
  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Bench for i2c_target_regs: a bit-banged I2C controller plus Wishbone tasks feed a scoreboard
// whose monitor compares I2C observations, Wishbone acks and o_int pulses against queued expectations.
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_o, sda_oe, wb_ack_o, o_int;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_adr_i = '0;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;

  assign sda_bus = sda_m & ~(sda_oe & ~sda_o);

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_oe(sda_oe),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .o_int(o_int)
  );

  typedef struct { int kind; logic [31:0] val; } item_t;
  typedef struct { bit is_read; logic [31:0] val; } wb_item_t;

  item_t    i2c_exp[$];
  item_t    i2c_obs[$];
  wb_item_t wb_exp[$];
  int       int_exp_cnt = 0;
  int       n_checks = 0;
  int       n_pass = 0;
  int       oe_cnt = 0;
  logic     ack_prev = 1'b0;
  logic     int_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic string kname(input int k);
    case (k)
      0:       return "i2c_ack_bit";
      1:       return "i2c_read_byte";
      2:       return "sda_oe_quiet";
      3:       return "sda_oe_driving_before_reset";
      4:       return "sda_oe_after_reset";
      default: return "unknown";
    endcase
  endfunction

  // monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    item_t    e, o;
    wb_item_t w;
    if (sda_oe) oe_cnt++;
    if (wb_ack_o) begin
      check("wb_ack_one_cycle", {31'b0, ack_prev}, 32'd0);
      check("wb_ack_expected", {31'b0, wb_exp.size() > 0}, 32'd1);
      if (wb_exp.size() > 0) begin
        w = wb_exp.pop_front();
        if (w.is_read) check("wb_read_data", wb_dat_o, w.val);
      end
    end
    ack_prev = wb_ack_o;
    if (o_int) begin
      check("o_int_one_cycle", {31'b0, int_prev}, 32'd0);
      check("o_int_expected", {31'b0, int_exp_cnt > 0}, 32'd1);
      if (int_exp_cnt > 0) int_exp_cnt--;
    end
    int_prev = o_int;
    while (i2c_obs.size() > 0) begin
      o = i2c_obs.pop_front();
      check("i2c_exp_available", {31'b0, i2c_exp.size() > 0}, 32'd1);
      if (i2c_exp.size() > 0) begin
        e = i2c_exp.pop_front();
        check(kname(e.kind), o.val, e.val);
      end
    end
  end

  task automatic tq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input int kind, input logic [31:0] exp, input logic [31:0] act);
    i2c_exp.push_back('{kind, exp});
    i2c_obs.push_back('{kind, act});
  endtask

  task automatic bit_out(input logic b, output logic s);
    sda_m = b; tq();
    scl_m = 1'b1; tq();
    s = sda_bus; tq();
    scl_m = 1'b0; tq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tq();
    scl_m = 1'b1; tq();
    sda_m = 1'b0; tq();
    scl_m = 1'b0; tq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tq();
    scl_m = 1'b1; tq();
    sda_m = 1'b1; tq();
  endtask

  task automatic i2c_wbyte(input logic [7:0] b, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, s);
    expect_obs(0, {31'b0, exp_ack}, {31'b0, s});
  endtask

  task automatic i2c_rbyte(input logic [7:0] exp, input logic nack);
    logic       s;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    bit_out(nack, s);
    expect_obs(1, {24'b0, exp}, {24'b0, d});
  endtask

  // data byte whose 8th rising edge coincides with a Wishbone write of 0x55 to reg[2]
  task automatic i2c_wbyte_collide(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 1; i--) bit_out(b[i], s);
    sda_m = b[0]; tq();
    scl_m = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    wb_exp.push_back('{1'b0, 32'd0});
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'd2; wb_dat_i = 32'h55;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (Q - 3) @(posedge clk); #1;
    tq();
    scl_m = 1'b0; tq();
    bit_out(1'b1, s);
    expect_obs(0, 32'd0, {31'b0, s});
  endtask

  task automatic wb_access(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                           input logic [7:0] exp);
    int n;
    wb_exp.push_back('{!we, {24'b0, exp}});
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = {24'hABCDEF, dat};
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && n < 8);
    check("wb_ack_within_budget", {31'b0, wb_ack_o}, 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic s;
    int   snap;
    repeat (3) @(posedge clk); #1;
    check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("rst_wb_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_wb_dat", wb_dat_o, 32'd0);
    check("rst_o_int", {31'b0, o_int}, 32'd0);
    reset_n = 1'b1; tq();

    wb_access(1'b0, 4'd3, 8'h00, 8'h00);
    wb_access(1'b1, 4'd7, 8'h5A, 8'h00);
    wb_access(1'b0, 4'd7, 8'h00, 8'h5A);

    // write transaction
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_wbyte(8'h03, 1'b0);
    i2c_wbyte(8'hAA, 1'b0);
    i2c_wbyte(8'hBB, 1'b0);
    int_exp_cnt++;
    i2c_stop(); tq();
    wb_access(1'b0, 4'd3, 8'h00, 8'hAA);
    wb_access(1'b0, 4'd4, 8'h00, 8'hBB);

    // read after write with repeated START; the trailing byte checks the bus is released
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_wbyte(8'h03, 1'b0);
    i2c_start();
    i2c_wbyte(8'h85, 1'b0);
    i2c_rbyte(8'hAA, 1'b0);
    i2c_rbyte(8'hBB, 1'b1);
    i2c_rbyte(8'hFF, 1'b1);
    i2c_stop(); tq();

    // address mismatch
    snap = oe_cnt;
    i2c_start();
    i2c_wbyte(8'h90, 1'b1);
    i2c_wbyte(8'h00, 1'b1);
    i2c_wbyte(8'h12, 1'b1);
    i2c_stop(); tq();
    expect_obs(2, 32'd0, oe_cnt - snap);
    wb_access(1'b0, 4'd0, 8'h00, 8'h00);
    wb_access(1'b0, 4'd3, 8'h00, 8'hAA);

    // pointer wrap-around
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_wbyte(8'h0F, 1'b0);
    i2c_wbyte(8'h11, 1'b0);
    i2c_wbyte(8'h22, 1'b0);
    int_exp_cnt++;
    i2c_stop(); tq();
    wb_access(1'b0, 4'd15, 8'h00, 8'h11);
    wb_access(1'b0, 4'd0, 8'h00, 8'h22);

    // same-clk collision on reg[2]
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_wbyte(8'h02, 1'b0);
    i2c_wbyte_collide(8'h66);
    int_exp_cnt++;
    i2c_stop(); tq();
    wb_access(1'b0, 4'd2, 8'h00, 8'h66);

    // reset during bit 3 of a read of reg[0]=0x22 (bit 3 is 0, so SDA is being pulled low)
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_wbyte(8'h00, 1'b0);
    i2c_start();
    i2c_wbyte(8'h85, 1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1, s);
    sda_m = 1'b1; tq();
    expect_obs(3, 32'd1, {31'b0, sda_oe});
    reset_n = 1'b0; #1;
    expect_obs(4, 32'd0, {31'b0, sda_oe});
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    scl_m = 1'b1; tq(); tq();
    scl_m = 1'b0; tq();
    for (int i = 0; i < 5; i++) bit_out(1'b1, s);
    snap = oe_cnt;
    i2c_wbyte(8'h84, 1'b1);
    expect_obs(2, 32'd0, oe_cnt - snap);
    i2c_stop(); tq();
    i2c_start();
    i2c_wbyte(8'h84, 1'b0);
    i2c_stop(); tq();
    wb_access(1'b0, 4'd0, 8'h00, 8'h00);

    repeat (20) @(posedge clk); #1;
    check("wb_exp_drained", wb_exp.size(), 32'd0);
    check("i2c_exp_drained", i2c_exp.size(), 32'd0);
    check("o_int_exp_drained", int_exp_cnt, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
